// File: rtl/mem_pkg.sv
// mem_pkg: funct3 width codes and FSM state encoding shared by the data memory responder
package mem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
endpackage

// File: rtl/byte_lane_align.sv
// byte_lane_align: little-endian store byte-enable/data replication and load extract/extend
module byte_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wlane,
  output logic [31:0] rdata
);
  logic is_w, is_h, sx;
  logic [31:0] sh;
  assign is_w = funct3 == F3_W;
  assign is_h = funct3[1:0] == F3_H[1:0];
  assign sx = funct3[2] == F3_B[2];
  assign sh = rword >> {off, 3'b000};
  // lane selection; replicated store data lets the byte enables pick the lane
  always_comb begin
    be = is_w ? 4'hF : is_h ? 4'b0011 << off : 4'b0001 << off;
    wlane = is_w ? wdata : is_h ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    rdata = is_w ? sh : is_h ? {{16{sx & sh[15]}}, sh[15:0]} : {{24{sx & sh[7]}}, sh[7:0]};
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-state data memory with valid/ready handshake; MEM_MISALIGN_TRAP_EN traps misaligned H/W
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAST = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
  state_t state, state_n;
  logic [3:0] cnt;
  logic wr_q;
  logic [AW+1:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0] f3_q;
  logic [31:0] mem [DEPTH_WORDS];
  logic wr, bad_f3, mis, err, enter_resp, unused_addr;
  logic [AW+1:0] addr;
  logic [AW-1:0] idx;
  logic [31:0] wdata, wlane, ld, mask;
  logic [2:0] f3;
  logic [1:0] off;
  logic [3:0] be;
  assign unused_addr = ^req_addr[31:AW+2];
  assign wr = state == IDLE ? req_write : wr_q;
  assign addr = state == IDLE ? req_addr[AW+1:0] : addr_q;
  assign wdata = state == IDLE ? req_wdata : wdata_q;
  assign f3 = state == IDLE ? req_funct3 : f3_q;
  assign idx = addr[AW+1:2];
  assign bad_f3 = f3 == 3'b011 || f3[2:1] == 2'b11 || (wr && f3[2]);
  assign mis = (f3[1:0] == F3_H[1:0] && addr[0]) || (f3 == F3_W && addr[1:0] != 2'b00);
`ifdef MEM_MISALIGN_TRAP_EN
  assign err = bad_f3 || mis;
`else
  assign err = bad_f3;
`endif
  assign off = f3 == F3_W ? 2'b00 : f3[0] ? {addr[1], 1'b0} : addr[1:0];
  assign mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign enter_resp = state_n == RESP && state != RESP;
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  byte_lane_align u_lane (
    .funct3(f3),
    .off(off),
    .wdata(wdata),
    .rword(mem[idx]),
    .be(be),
    .wlane(wlane),
    .rdata(ld)
  );
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // next state: accept only in IDLE, count wait states, hold response until consumed
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = req_valid ? (WAIT_CYCLES == 0 ? RESP : ACCESS) : IDLE;
      ACCESS: state_n = cnt == LAST ? RESP : ACCESS;
      RESP: state_n = rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  // request capture, wait counter and registered response
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      f3_q <= '0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      cnt <= state == ACCESS ? cnt + 4'd1 : '0;
      if (state == IDLE && req_valid) begin
        wr_q <= req_write;
        addr_q <= req_addr[AW+1:0];
        wdata_q <= req_wdata;
        f3_q <= req_funct3;
      end
      if (enter_resp) begin
        rsp_rdata <= (wr || err) ? '0 : ld;
        rsp_error <= err;
      end
    end
  // memory array, not reset; stores commit only on the edge that enters RESP
  always_ff @(posedge clk)
    if (enter_resp && wr && !err) mem[idx] <= (mem[idx] & ~mask) | (wlane & mask);
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed self-checking bench for data_mem_responder
module tb_data_mem_responder;
  logic clk = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0] req_funct3 = 3'b010;
  logic rsp_valid, rsp_ready = 1'b0, rsp_error;
  logic [31:0] rsp_rdata;
  int total = 0, bad = 0;
  data_mem_responder dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_funct3(req_funct3), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );
  always #5 clk = ~clk;
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] f, output logic [31:0] rd, output logic e, output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_funct3 = f;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = ~w; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A; req_funct3 = 3'b011;
    lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    rd = rsp_rdata; e = rsp_error;
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask
  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
    total++; if (rsp_error !== 1'b0) begin bad++; $display("FAIL reset_rsp_error got=%b exp=0", rsp_error); end
    reset = 1'b0;
  endtask
  task automatic test_word;
    logic [31:0] rd; logic e; int lat;
    xfer(1'b1, 32'h10, 32'h1234_5678, 3'b010, rd, e, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL sw_latency got=%0d exp=3", lat); end
    total++; if (rd !== 32'h0 || e !== 1'b0) begin bad++; $display("FAIL sw_rsp got=%h/%b exp=0/0", rd, e); end
    xfer(1'b0, 32'h10, 32'h0, 3'b010, rd, e, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL lw_latency got=%0d exp=3", lat); end
    total++; if (rd !== 32'h1234_5678) begin bad++; $display("FAIL lw_word got=%h exp=12345678", rd); end
  endtask
  task automatic test_byte;
    logic [31:0] rd; logic e; int lat;
    xfer(1'b1, 32'h13, 32'h1122_33AB, 3'b000, rd, e, lat);
    total++; if (e !== 1'b0) begin bad++; $display("FAIL sb_error got=%b exp=0", e); end
    xfer(1'b0, 32'h13, 32'h0, 3'b000, rd, e, lat);
    total++; if (rd !== 32'hFFFF_FFAB) begin bad++; $display("FAIL lb_sext got=%h exp=ffffffab", rd); end
    xfer(1'b0, 32'h13, 32'h0, 3'b100, rd, e, lat);
    total++; if (rd !== 32'h0000_00AB) begin bad++; $display("FAIL lbu_zext got=%h exp=000000ab", rd); end
    xfer(1'b0, 32'h10, 32'h0, 3'b010, rd, e, lat);
    total++; if (rd !== 32'hAB34_5678) begin bad++; $display("FAIL lw_after_sb got=%h exp=ab345678", rd); end
    xfer(1'b0, 32'h12, 32'h0, 3'b101, rd, e, lat);
    total++; if (rd !== 32'h0000_AB34) begin bad++; $display("FAIL lhu_upper got=%h exp=0000ab34", rd); end
  endtask
  task automatic test_stall;
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010;
    @(posedge clk); #1 req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL stall_timeout got=%b exp=1", rsp_valid); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hAB34_5678 || req_ready !== 1'b0) begin
        bad++; $display("FAIL stall_hold cyc=%0d got=%b/%h/%b exp=1/ab345678/0", i, rsp_valid, rsp_rdata, req_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL stall_release got=%b/%b exp=1/0", req_ready, rsp_valid); end
  endtask
  task automatic test_reset_abort;
    logic [31:0] rd; logic e; int lat;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'hDEAD_BEEF; req_funct3 = 3'b010;
    @(posedge clk); #1 req_valid = 1'b0;
    reset = 1'b1;
    #2;
    total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL abort_async got=%b/%b exp=1/0", req_ready, rsp_valid); end
    reset = 1'b0;
    xfer(1'b0, 32'h10, 32'h0, 3'b010, rd, e, lat);
    total++; if (rd !== 32'hAB34_5678) begin bad++; $display("FAIL abort_nowrite got=%h exp=ab345678", rd); end
  endtask
  task automatic test_misalign;
    logic [31:0] rd; logic e; int lat;
    logic [31:0] exp_h, exp_w;
    logic exp_e;
`ifdef MEM_MISALIGN_TRAP_EN
    exp_e = 1'b1; exp_h = 32'h0; exp_w = 32'h0;
`else
    exp_e = 1'b0; exp_h = 32'h0000_5678; exp_w = 32'hAB34_5678;
`endif
    xfer(1'b0, 32'h11, 32'h0, 3'b001, rd, e, lat);
    total++; if (rd !== exp_h || e !== exp_e) begin bad++; $display("FAIL lh_misalign got=%h/%b exp=%h/%b", rd, e, exp_h, exp_e); end
    xfer(1'b0, 32'h12, 32'h0, 3'b010, rd, e, lat);
    total++; if (rd !== exp_w || e !== exp_e) begin bad++; $display("FAIL lw_misalign got=%h/%b exp=%h/%b", rd, e, exp_w, exp_e); end
  endtask
  task automatic test_wrap_illegal;
    logic [31:0] rd; logic e; int lat;
    xfer(1'b1, 32'h104, 32'hCAFE_F00D, 3'b010, rd, e, lat);
    xfer(1'b0, 32'h4, 32'h0, 3'b010, rd, e, lat);
    total++; if (rd !== 32'hCAFE_F00D) begin bad++; $display("FAIL wrap got=%h exp=cafef00d", rd); end
    xfer(1'b0, 32'h4, 32'h0, 3'b011, rd, e, lat);
    total++; if (e !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL f3_011_load got=%h/%b exp=0/1", rd, e); end
    xfer(1'b1, 32'h4, 32'h1111_1111, 3'b011, rd, e, lat);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL f3_011_store got=%b exp=1", e); end
    xfer(1'b1, 32'h4, 32'h2222_2222, 3'b100, rd, e, lat);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL sbu_store got=%b exp=1", e); end
    xfer(1'b0, 32'h4, 32'h0, 3'b110, rd, e, lat);
    total++; if (e !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL f3_110_load got=%h/%b exp=0/1", rd, e); end
    xfer(1'b0, 32'h4, 32'h0, 3'b010, rd, e, lat);
    total++; if (rd !== 32'hCAFE_F00D || e !== 1'b0) begin bad++; $display("FAIL illegal_nowrite got=%h/%b exp=cafef00d/0", rd, e); end
  endtask
  initial begin
    test_reset;
    test_word;
    test_byte;
    test_stall;
    test_reset_abort;
    test_misalign;
    test_wrap_illegal;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: wait states between request accept and response (0..15).
REQ-002 Parameter DEPTH_WORDS, default 64: number of 32-bit memory words; power of two.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  requester presents an access.
REQ-006 req_ready  output  1  responder can accept an access this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  requester consumes the response.
REQ-013 rsp_rdata  output  32  load result, extended per funct3; 0 for stores and errors.
REQ-014 rsp_error  output  1  access rejected; qualified by rsp_valid.

Function
REQ-015 The FSM SHALL have states IDLE, ACCESS and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 The request SHALL be accepted on a cycle with req_valid=1 in IDLE; all req_* fields SHALL be captured at accept, and later changes SHALL be ignored.
REQ-017 After accept, the FSM SHALL go to ACCESS, spend WAIT_CYCLES cycles there, then enter RESP; if WAIT_CYCLES=0 it SHALL go straight from IDLE to RESP.
REQ-018 rsp_valid SHALL first assert WAIT_CYCLES+1 cycles after the accept edge and hold with stable rsp_rdata/rsp_error until rsp_ready=1; then the FSM SHALL return to IDLE.
REQ-019 rsp_ready=1 in RESP SHALL complete the transfer on that edge; back-to-back requests SHALL need at least one IDLE cycle (no accept in RESP).
REQ-020 Word index SHALL be req_addr[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-021 Byte order SHALL be little-endian; req_addr[1:0] SHALL select the lane.
REQ-022 Stores SHALL write only the addressed byte (B), halfword (H) or full word (W), leaving other bytes unchanged.
REQ-023 A store SHALL commit on the edge that enters RESP, never earlier.
REQ-024 Loads SHALL sign-extend for B/H and zero-extend for BU/HU.
REQ-025 funct3 011, 110 or 111 SHALL produce rsp_error=1, rsp_rdata=0, and no memory write, whatever the configuration.
REQ-026 A store with funct3 BU/HU SHALL be treated as illegal per REQ-025.

Reset
REQ-027 Reset SHALL force IDLE, wait counter 0, req_ready=1, rsp_valid=0, rsp_rdata=0 and rsp_error=0, asynchronously.
REQ-028 Reset asserted in ACCESS SHALL discard the pending access, with no memory write; reset in RESP SHALL drop the response.
REQ-029 Memory contents SHALL NOT be reset; simulation initial content SHALL be all zero.

Configuration
REQ-030 With MEM_MISALIGN_TRAP_EN defined, a misaligned H/HU (addr[0]=1) or W (addr[1:0]!=0) SHALL give rsp_error=1, rsp_rdata=0 and no write.
REQ-031 Without MEM_MISALIGN_TRAP_EN, misaligned accesses SHALL force the offending low address bits to 0 and complete normally with rsp_error=0.

Structure
REQ-032 Shared package mem_pkg SHALL hold the funct3 width codes and the FSM state encoding.
REQ-033 Lane logic SHALL sit in a combinational sub-module byte_lane_align: store byte-enable/data shift, load extract and extend.

Verification
REQ-034 Reset, then SW 0x12345678 @0x10, then LW @0x10 -> rsp_rdata=0x12345678; rsp_valid asserts exactly 3 cycles after each accept (WAIT_CYCLES=2).
REQ-035 After REQ-034, SB 0xAB @0x13, then LB @0x13 -> 0xFFFFFFAB; LBU @0x13 -> 0x000000AB; LW @0x10 -> 0xAB345678.
REQ-036 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stay stable and req_ready=0; raising rsp_ready gives one IDLE cycle with req_ready=1.
REQ-037 SW 0xDEADBEEF @0x10, reset pulse in the first ACCESS cycle, then LW @0x10 -> the previous value is returned unchanged.
REQ-038 LH @0x11: with MEM_MISALIGN_TRAP_EN -> rsp_error=1, rdata=0; without it -> rsp_error=0, rdata = sign-extended halfword @0x10.
REQ-039 SW @(DEPTH_WORDS*4 + 0x4), then LW @0x4 -> same data (wrap); funct3=011 -> rsp_error=1 in both configurations.
